// File: rtl/data_memory_sized.sv
// Byte-addressable data memory for the MEM stage: byte/half/word access, misalignment flagging,
// sticky error flag. Define DM_CLEAR_EN to build the post-reset clear engine that drives Busy.
module data_memory_sized #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Misaligned,
  output logic        ErrSticky
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] word_idx_s;
  logic [1:0]            lane_s;
  logic [31:0]           word_s;
  logic [31:0]           load_s;
  logic                  busy_s;
  logic                  mis_s;
  logic                  store_en_s;
  logic                  err_r;
  logic                  unused_addr_s;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic res;
    case (size)
      2'b00:   res = 1'b0;
      2'b01:   res = lane[0];
      2'b10:   res = |lane;
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] old_w, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] res;
    res = old_w;
    case (size)
      2'b00:   res[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01:   res[{lane[1], 4'b0000} +: 16] = wd[15:0];
      2'b10:   res = wd;
      default: res = old_w;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] w, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sgn);
    logic [31:0] res;
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   res = {{24{sgn & b[7]}}, b};
      2'b01:   res = {{16{sgn & h[15]}}, h};
      2'b10:   res = w;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  assign word_idx_s    = Address[ADDR_WIDTH+1:2];
  assign lane_s        = Address[1:0];
  assign unused_addr_s = &{1'b0, Address[31:ADDR_WIDTH+2]};
  assign word_s        = mem_r[word_idx_s];
  assign mis_s         = (MemRead | MemWrite) & is_misaligned(MemSize, lane_s);
  assign store_en_s    = MemWrite & ~busy_s & ~mis_s;

`ifdef DM_CLEAR_EN
  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [ADDR_WIDTH-1:0] idx_r;
  logic [ADDR_WIDTH-1:0] idx_nxt_s;
  logic                  clear_we_s;

  // Clear engine state and index register; reset restarts the sweep from word 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_CLEAR;
      idx_r   <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Clear engine next state: sweep every word once, then hold idx in READY.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    clear_we_s  = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        clear_we_s = 1'b1;
        if (idx_r == {ADDR_WIDTH{1'b1}}) begin
          state_nxt_s = ST_READY;
        end else begin
          idx_nxt_s = idx_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      ST_READY: begin
        state_nxt_s = ST_READY;
      end
      default: begin
        state_nxt_s = ST_CLEAR;
      end
    endcase
  end

  assign busy_s = (state_r == ST_CLEAR);

  // Memory array write port: clear sweep has priority over (already blocked) stores.
  always_ff @(posedge clk) begin
    if (clear_we_s) begin
      mem_r[idx_r] <= 32'h0000_0000;
    end else if (store_en_s) begin
      mem_r[word_idx_s] <= merge_store(word_s, WriteData, MemSize, lane_s);
    end
  end
`else
  assign busy_s = 1'b0;

  // Memory array write port; contents are not initialised by reset.
  always_ff @(posedge clk) begin
    if (store_en_s) begin
      mem_r[word_idx_s] <= merge_store(word_s, WriteData, MemSize, lane_s);
    end
  end
`endif

  // Sticky misalignment error, ignored while the clear engine owns the array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else if (mis_s && !busy_s) begin
      err_r <= 1'b1;
    end
  end

  // Combinational load path; old contents are shown even when a same-word store is pending.
  always_comb begin
    load_s = 32'h0000_0000;
    if (MemRead && !busy_s && !mis_s) begin
      load_s = extract_load(word_s, MemSize, lane_s, MemSigned);
    end else begin
      load_s = 32'h0000_0000;
    end
  end

  assign ReadData   = load_s;
  assign Busy       = busy_s;
  assign Misaligned = mis_s;
  assign ErrSticky  = err_r;

endmodule

// File: tb/tb_data_memory_sized.sv
// Self-checking bench for data_memory_sized against a byte-array reference model.
// Covers both builds (DM_CLEAR_EN defined or not).
module tb_data_memory_sized;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, MemSigned;
  logic [1:0]  MemSize;
  logic [31:0] Address, WriteData;
  logic [31:0] ReadData;
  logic        Busy, Misaligned, ErrSticky;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mb [1024];
  bit model_ready = 1'b0;
  bit err_model = 1'b0;

  data_memory_sized #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize),
    .MemSigned(MemSigned), .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .Busy(Busy), .Misaligned(Misaligned), .ErrSticky(ErrSticky)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit exp_mis(input logic rd, input logic wr, input logic [1:0] sz, input logic [31:0] a);
    if (!(rd || wr)) return 1'b0;
    if (sz == 2'd3) return 1'b1;
    return (a % 32'(nbytes(sz))) != 32'd0;
  endfunction

  function automatic logic [31:0] exp_read(input logic rd, input logic wr, input logic [1:0] sz,
                                           input logic sg, input logic [31:0] a);
    logic [31:0] v;
    int n;
    if (!rd || exp_mis(rd, wr, sz, a)) return 32'd0;
    n = nbytes(sz);
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(mb[10'(a + 32'(i))]) << (8 * i));
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // Reference model: byte-array update on each live edge.
  always @(posedge clk) begin
    if (reset && model_ready) begin
      if (exp_mis(MemRead, MemWrite, MemSize, Address)) err_model <= 1'b1;
      else if (MemWrite) begin
        for (int i = 0; i < nbytes(MemSize); i++)
          mb[10'(Address + 32'(i))] <= 8'(WriteData >> (8 * i));
      end
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg; Address = a; WriteData = wd;
    #1;
  endtask

  task automatic idle_inputs();
    MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'd2; MemSigned = 1'b0;
    Address = 32'd0; WriteData = 32'd0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
  endtask

  // Counts rising edges from reset release until Busy falls (bounded).
  task automatic count_busy_edges(output int n);
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      #1;
      if (Busy !== 1'b1) break;
    end
  endtask

  task automatic test_reset();
    logic busy_exp;
`ifdef DM_CLEAR_EN
    busy_exp = 1'b1;
`else
    busy_exp = 1'b0;
`endif
    reset = 1'b0; model_ready = 1'b0; err_model = 1'b0;
    idle_inputs();
    #3;
    vectors++; if (Busy !== busy_exp) begin miscompares++; $display("FAIL reset_busy: got %b expected %b", Busy, busy_exp); end
    vectors++; if (ErrSticky !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", ErrSticky); end
    vectors++; if (ReadData !== 32'd0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 0", ReadData); end
    MemRead = 1'b1; Address = 32'h1; #1;
    vectors++; if (Misaligned !== 1'b1) begin miscompares++; $display("FAIL reset_mis: got %b expected 1", Misaligned); end
    idle_inputs();
    repeat (2) @(posedge clk);
  endtask

  task automatic test_clear();
    int n;
    @(negedge clk);
`ifdef DM_CLEAR_EN
    MemRead = 1'b1; MemWrite = 1'b1; MemSize = 2'd2; Address = 32'h10; WriteData = 32'hDEADBEEF;
    reset = 1'b1;
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      #1;
      if (Busy !== 1'b1) break;
      if (n == 1) begin
        vectors++; if (ReadData !== 32'd0) begin miscompares++; $display("FAIL busy_rdata: got %h expected 0", ReadData); end
      end
      if (n == 3) Address = 32'h13;
      if (n == 5) idle_inputs();
    end
    vectors++; if (n != 256) begin miscompares++; $display("FAIL clear_edges: got %0d expected 256", n); end
    clear_model();
    model_ready = 1'b1;
    vectors++; if (ErrSticky !== 1'b0) begin miscompares++; $display("FAIL clear_err: got %b expected 0", ErrSticky); end
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    vectors++; if (ReadData !== 32'd0) begin miscompares++; $display("FAIL busy_store: got %h expected 0", ReadData); end
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h3FC, 32'd0);
    vectors++; if (ReadData !== 32'd0) begin miscompares++; $display("FAIL clear_3fc: got %h expected 0", ReadData); end
`else
    reset = 1'b1;
    #1;
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL nobusy: got %b expected 0", Busy); end
    model_ready = 1'b1;
    for (int w = 0; w < 256; w++) drive(1'b0, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom);
    n = 0;
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h3FC, 32'd0);
    vectors++; if (ReadData !== exp_read(1'b1, 1'b0, 2'd2, 1'b0, 32'h3FC)) begin miscompares++; $display("FAIL preload_3fc: got %h expected %h", ReadData, exp_read(1'b1, 1'b0, 2'd2, 1'b0, 32'h3FC)); end
`endif
  endtask

  task automatic test_mixed();
    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344);
    drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h123456AA);
    drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h9876BEEF);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    vectors++; if (ReadData !== 32'hBEEFAA44) begin miscompares++; $display("FAIL mixed_word: got %h expected BEEFAA44", ReadData); end
    drive(1'b1, 1'b0, 2'd0, 1'b1, 32'h21, 32'd0);
    vectors++; if (ReadData !== 32'hFFFFFFAA) begin miscompares++; $display("FAIL sbyte: got %h expected FFFFFFAA", ReadData); end
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h21, 32'd0);
    vectors++; if (ReadData !== 32'h000000AA) begin miscompares++; $display("FAIL ubyte: got %h expected 000000AA", ReadData); end
    drive(1'b1, 1'b0, 2'd1, 1'b1, 32'h22, 32'd0);
    vectors++; if (ReadData !== 32'hFFFFBEEF) begin miscompares++; $display("FAIL shalf: got %h expected FFFFBEEF", ReadData); end
    drive(1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 32'd0);
    vectors++; if (ReadData !== 32'h0000BEEF) begin miscompares++; $display("FAIL uhalf: got %h expected 0000BEEF", ReadData); end
    drive(1'b1, 1'b0, 2'd2, 1'b1, 32'h20, 32'd0);
    vectors++; if (ReadData !== 32'hBEEFAA44) begin miscompares++; $display("FAIL sword: got %h expected BEEFAA44", ReadData); end
  endtask

  task automatic test_misaligned();
    logic [31:0] e;
    vectors++; if (ErrSticky !== 1'b0) begin miscompares++; $display("FAIL err_pre: got %b expected 0", ErrSticky); end
    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h41, 32'h12345678);
    vectors++; if (Misaligned !== 1'b1) begin miscompares++; $display("FAIL mis_store: got %b expected 1", Misaligned); end
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
    e = exp_read(1'b1, 1'b0, 2'd2, 1'b0, 32'h40);
    vectors++; if (ErrSticky !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b expected 1", ErrSticky); end
    vectors++; if (ReadData !== e) begin miscompares++; $display("FAIL mis_nochange: got %h expected %h", ReadData, e); end
    drive(1'b1, 1'b0, 2'd1, 1'b0, 32'h43, 32'd0);
    vectors++; if (Misaligned !== 1'b1) begin miscompares++; $display("FAIL mis_half: got %b expected 1", Misaligned); end
    vectors++; if (ReadData !== 32'd0) begin miscompares++; $display("FAIL mis_half_rd: got %h expected 0", ReadData); end
    drive(1'b1, 1'b0, 2'd3, 1'b0, 32'h0, 32'd0);
    vectors++; if (Misaligned !== 1'b1) begin miscompares++; $display("FAIL mis_rsvd: got %b expected 1", Misaligned); end
    vectors++; if (ReadData !== 32'd0) begin miscompares++; $display("FAIL mis_rsvd_rd: got %h expected 0", ReadData); end
    drive(1'b0, 1'b0, 2'd3, 1'b0, 32'h43, 32'd0);
    vectors++; if (Misaligned !== 1'b0) begin miscompares++; $display("FAIL mis_noreq: got %b expected 0", Misaligned); end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'd0);
    vectors++; if (ReadData !== 32'hCAFEF00D) begin miscompares++; $display("FAIL wrap_word: got %h expected CAFEF00D", ReadData); end
    drive(1'b1, 1'b0, 2'd1, 1'b0, 32'hFFFF_F402, 32'd0);
    vectors++; if (ReadData !== 32'h0000CAFE) begin miscompares++; $display("FAIL wrap_half: got %h expected 0000CAFE", ReadData); end
  endtask

  task automatic test_same_word();
    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h80, 32'h77665544);
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h80, 32'h5);
    vectors++; if (ReadData !== 32'h77665544) begin miscompares++; $display("FAIL rw_old: got %h expected 77665544", ReadData); end
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'd0);
    vectors++; if (ReadData !== 32'h5) begin miscompares++; $display("FAIL rw_new: got %h expected 00000005", ReadData); end
  endtask

  task automatic test_random();
    logic rd, wr, sg;
    logic [1:0] sz;
    logic [31:0] a, e;
    bit m;
    for (int k = 0; k < 200; k++) begin
      rd = 1'($urandom); wr = 1'($urandom); sg = 1'($urandom);
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~(32'(nbytes(sz)) - 32'd1);
      drive(rd, wr, sz, sg, a, $urandom);
      m = exp_mis(rd, wr, sz, a);
      e = exp_read(rd, wr, sz, sg, a);
      vectors++; if (Misaligned !== m) begin miscompares++; $display("FAIL rand_mis: addr %h got %b expected %b", a, Misaligned, m); end
      vectors++; if (ReadData !== e) begin miscompares++; $display("FAIL rand_rd: addr %h got %h expected %h", a, ReadData, e); end
    end
    drive(1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0);
    vectors++; if (ErrSticky !== err_model) begin miscompares++; $display("FAIL rand_err: got %b expected %b", ErrSticky, err_model); end
  endtask

  task automatic test_reset_midclear();
    int n;
    model_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0; err_model = 1'b0;
`ifdef DM_CLEAR_EN
    @(negedge clk);
    reset = 1'b1;
    MemRead = 1'b1; MemSize = 2'd3;
    repeat (100) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b expected 1", Busy); end
    @(negedge clk);
    reset = 1'b1;
    count_busy_edges(n);
    vectors++; if (n != 256) begin miscompares++; $display("FAIL mid_edges: got %0d expected 256", n); end
    vectors++; if (ErrSticky !== 1'b0) begin miscompares++; $display("FAIL mid_err: got %b expected 0", ErrSticky); end
    idle_inputs();
    clear_model();
    model_ready = 1'b1;
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    vectors++; if (ReadData !== 32'd0) begin miscompares++; $display("FAIL mid_clear20: got %h expected 0", ReadData); end
`else
    #1;
    vectors++; if (ErrSticky !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b expected 0", ErrSticky); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", Busy); end
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    model_ready = 1'b1;
    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0BADF00D);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    vectors++; if (ReadData !== 32'h0BADF00D) begin miscompares++; $display("FAIL post_rst_store: got %h expected 0BADF00D", ReadData); end
`endif
  endtask

  initial begin
    test_reset();
    test_clear();
    test_mixed();
    test_misaligned();
    test_wrap();
    test_same_word();
    test_random();
    test_reset_midclear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
